// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and width limit for the bit-serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
    localparam int SA_MAX_WIDTH = 32;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from two half_adder cells and an OR of their carries.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0, c0, c1;
    half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0), .c_o(c0));
    half_adder u_ha1 (.a_i(s0), .b_i(c_i), .s_o(s_o), .c_o(c1));
    assign c_o = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit sum and carry of two inputs.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: valid/ready LSB-first bit-serial adder, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub input selecting A - B.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
    logic [WIDTH-2:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, co_q, b_bit, fa_s, fa_c, accept, last;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    assign b_bit = b_sh_q[0] ^ sub_q;
`else
    assign b_bit = b_sh_q[0];
`endif

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (state_q == SHIFT) && (cnt_q == LAST);

    full_adder u_fa (.a_i(a_sh_q[0]), .b_i(b_bit), .c_i(c_q), .s_o(fa_s), .c_o(fa_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q <= a;
                b_sh_q <= b;
                cnt_q  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                sub_q  <= sub;
                c_q    <= sub;
`else
                c_q    <= 1'b0;
`endif
            end else if (state_q == SHIFT) begin
                a_sh_q <= a_sh_q >> 1;
                b_sh_q <= b_sh_q >> 1;
                res_q  <= (WIDTH-1)'({fa_s, res_q} >> 1);
                cnt_q  <= cnt_q + CW'(1);
                c_q    <= fa_c;
                // Published outputs only change on completion, so sum holds through IDLE.
                if (last) begin
                    sum_q <= {fa_s, res_q};
                    co_q  <= fa_c;
                end
            end
        end
    end

    always_comb begin
        state_d = (state_q == IDLE)  ? (in_valid ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) :
                                       (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        carry_out = co_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid, carry_out;
    logic [7:0] sum;
    int         errors = 0;
    int         checks = 0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_r = 1'b0;
`endif

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_r),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operand pair, verify out_valid stays low for 7 edges and rises on the 8th.
    task automatic start(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready", 32'(in_ready), 0);
        for (int i = 1; i < 8; i++) tick();
        chk("early_valid", 32'(out_valid), 0);
        tick();
        chk("done_valid", 32'(out_valid), 1);
    endtask

    task automatic result(input string tag, input logic [7:0] s, input logic c);
        chk({tag, "_sum"}, 32'(sum), 32'(s));
        chk({tag, "_carry"}, 32'(carry_out), 32'(c));
    endtask

    task automatic finish_op(input logic [7:0] s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_ready", 32'(in_ready), 1);
        chk("idle_sum_held", 32'(sum), 32'(s));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_carry", 32'(carry_out), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ready_no_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        start(8'd3, 8'd5);
        result("3p5", 8'd8, 1'b0);
        finish_op(8'd8);

        start(8'd255, 8'd1);
        result("255p1", 8'd0, 1'b1);
        finish_op(8'd0);

        start(8'd0, 8'd0);
        result("0p0", 8'd0, 1'b0);
        finish_op(8'd0);

        start(8'd170, 8'd85);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_sum", 32'(sum), 255);
        end
        result("170p85", 8'd255, 1'b0);
        finish_op(8'd255);

        // in_valid during SHIFT must be ignored
        a = 8'd3;
        b = 8'd4;
        in_valid = 1'b1;
        tick();
        a = 8'd9;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("shift_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("ign_early_valid", 32'(out_valid), 0);
        tick();
        chk("ign_done_valid", 32'(out_valid), 1);
        result("3p4_ign", 8'd7, 1'b0);
        finish_op(8'd7);

        // reset three edges into SHIFT discards the operation
        a = 8'd100;
        b = 8'd27;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_emit", 32'(out_valid), 0);
        start(8'd1, 8'd2);
        result("1p2", 8'd3, 1'b0);
        finish_op(8'd3);

`ifdef SERIAL_ADDER_SUB_EN
        sub_r = 1'b1;
        start(8'd5, 8'd7);
        sub_r = 1'b0;
        result("5m7", 8'd254, 1'b0);
        finish_op(8'd254);
        sub_r = 1'b1;
        start(8'd7, 8'd5);
        sub_r = 1'b0;
        result("7m5", 8'd2, 1'b1);
        finish_op(8'd2);
        start(8'd7, 8'd5);
        result("7p5_add", 8'd12, 1'b0);
        finish_op(8'd12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
